// File: rtl/ldm_stm_sequencer.sv
//------------------------------------------------------------------------------
// ldm_stm_sequencer : LDM/STM multiple-register transfer sequencer with writeback
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ldm_stm_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic [7:0]  reg_list,
  input  logic [31:0] base_addr,
  input  logic [2:0]  base_reg,
  input  logic        wb_en,
  output logic        busy,
  output logic        done,
  output logic [3:0]  rf_read_addr,
  input  logic [31:0] rf_read_data,
  output logic [3:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        rf_write_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_is_load;
  logic        r_wb;
  logic [7:0]  r_pending;
  logic [2:0]  r_base_reg;
  logic [31:0] r_addr;

  logic [2:0]  w_cur;
  logic        w_accept;
  logic        w_last;
  logic        w_wb_req;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  assign w_cur    = lowest_set(r_pending);
  assign w_accept = (r_state == ST_XFER) && mem_ready;
  assign w_last   = ((r_pending & (r_pending - 8'd1)) == 8'd0);
  // A load into the base register must win over the updated base.
  assign w_wb_req = wb_en && !(is_load && reg_list[base_reg]);

  assign mem_wdata = rf_read_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_addr walks the transfer addresses and ends at base + 4*popcount,
  // which is exactly the writeback value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_load  <= 1'b0;
      r_wb       <= 1'b0;
      r_pending  <= 8'd0;
      r_base_reg <= 3'd0;
      r_addr     <= 32'd0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_is_load  <= is_load;
      r_wb       <= w_wb_req;
      r_pending  <= reg_list;
      r_base_reg <= base_reg;
      r_addr     <= base_addr;
    end else if (w_accept) begin
      r_pending  <= r_pending & (r_pending - 8'd1);
      r_addr     <= r_addr + 32'd4;
    end
  end

  always_comb begin
    w_next        = r_state;
    busy          = (r_state != ST_IDLE);
    done          = 1'b0;
    rf_read_addr  = 4'd0;
    rf_write_addr = 4'd0;
    rf_write_data = 32'd0;
    rf_write_en   = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'd0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (reg_list == 8'd0) ? ST_DONE : ST_XFER;
        end
      end
      ST_XFER: begin
        mem_req  = 1'b1;
        mem_we   = !r_is_load;
        mem_addr = r_addr;
        if (!r_is_load) begin
          rf_read_addr = {1'b0, w_cur};
        end
        if (w_accept) begin
          if (r_is_load) begin
            rf_write_en   = 1'b1;
            rf_write_addr = {1'b0, w_cur};
            rf_write_data = mem_rdata;
          end
          if (w_last) begin
            w_next = r_wb ? ST_WB : ST_DONE;
          end
        end
      end
      ST_WB: begin
        rf_write_en   = 1'b1;
        rf_write_addr = {1'b0, r_base_reg};
        rf_write_data = r_addr;
        w_next        = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
//------------------------------------------------------------------------------
// tb_ldm_stm_sequencer : scoreboard bench with a transaction-level reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic [7:0]  reg_list = 8'd0;
  logic [31:0] base_addr = 32'd0;
  logic [2:0]  base_reg = 3'd0;
  logic        wb_en = 1'b0;
  logic        busy, done;
  logic [3:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_write_en, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;

  ldm_stm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
    .reg_list(reg_list), .base_addr(base_addr), .base_reg(base_reg), .wb_en(wb_en),
    .busy(busy), .done(done), .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 = memory transfer, 1 = register write, 2 = done
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
  } evt_t;

  evt_t        exp_q[$];
  logic [31:0] tb_rf[8];
  logic [31:0] model_rf[8];
  logic        load_rf = 1'b0;
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, req_cnt = 0, wr_cnt = 0;
  int          ready_mode = 0;
  int          wc = 0;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'd0;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_9617;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return use_fixed ? fixed_data : fill(a);
  endfunction

  function automatic evt_t mk(input int k, input logic [31:0] a, input logic we, input logic [31:0] d);
    evt_t e;
    e.kind = k; e.a = a; e.we = we; e.d = d;
    return e;
  endfunction

  assign mem_rdata    = mem_word(mem_addr);
  assign rf_read_data = tb_rf[rf_read_addr[2:0]];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (load_rf) begin
      for (int i = 0; i < 8; i++) tb_rf[i] <= model_rf[i];
    end else if (rf_write_en) begin
      tb_rf[rf_write_addr[2:0]] <= rf_write_data;
    end
  end

  // mem_ready: 0 always high, 1 random, 2 three wait states per request, else low
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (mem_ready) wc = 0;
        if (mem_req) begin
          wc++;
          mem_ready = (wc > 3);
        end else begin
          wc = 0;
          mem_ready = 1'b0;
        end
      end
      default: mem_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input int kind, input logic [31:0] a, input logic we, input logic [31:0] d);
    evt_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h, required no event (cycle %0d)",
               kind, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_addr", a, e.a);
      chk("evt_we", {31'd0, we}, {31'd0, e.we});
      chk("evt_data", d, e.d);
    end
  endtask

  // Monitor: observes the DUT mid-cycle and retires expected events in order.
  logic        prev_stall = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
  logic        p_we = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_req", {31'd0, mem_req}, 32'd1);
        chk("stall_addr", mem_addr, p_addr);
        chk("stall_we", {31'd0, mem_we}, {31'd0, p_we});
        chk("stall_wdata", mem_wdata, p_wdata);
      end
      if (mem_req) begin
        req_cnt++;
        chk("req_busy", {31'd0, busy}, 32'd1);
      end
      if (mem_req && mem_ready) pop_chk(0, mem_addr, mem_we, mem_we ? mem_wdata : 32'd0);
      if (rf_write_en) begin
        wr_cnt++;
        pop_chk(1, {28'd0, rf_write_addr}, 1'b1, rf_write_data);
      end
      if (done) begin
        chk("done_busy", {31'd0, busy}, 32'd1);
        pop_chk(2, 32'd0, 1'b0, 32'd0);
      end
      prev_stall = mem_req && !mem_ready;
      p_addr     = mem_addr;
      p_we       = mem_we;
      p_wdata    = mem_wdata;
    end
  end

  // Reference model: the externally visible effects of one instruction.
  task automatic expect_op(input bit ld, input logic [7:0] list, input logic [31:0] base,
                           input logic [2:0] br, input bit wb);
    int          n;
    logic [31:0] a;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (list[i]) begin
        a = base + 32'(4 * n);
        if (ld) begin
          exp_q.push_back(mk(0, a, 1'b0, 32'd0));
          exp_q.push_back(mk(1, 32'(i), 1'b1, mem_word(a)));
          model_rf[i] = mem_word(a);
        end else begin
          exp_q.push_back(mk(0, a, 1'b1, model_rf[i]));
        end
        n++;
      end
    end
    if (n != 0 && wb && !(ld && list[br])) begin
      exp_q.push_back(mk(1, {29'd0, br}, 1'b1, base + 32'(4 * n)));
      model_rf[br] = base + 32'(4 * n);
    end
    exp_q.push_back(mk(2, 32'd0, 1'b0, 32'd0));
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a
  // rising edge in the cycle following DONE.
  task automatic run_op(input bit ld, input logic [7:0] list, input logic [31:0] base,
                        input logic [2:0] br, input bit wb,
                        output int lat, output int reqs, output int wrs);
    int st, dc, r0, w0;
    bit got;
    expect_op(ld, list, base, br, wb);
    r0 = req_cnt; w0 = wr_cnt;
    start = 1'b1; is_load = ld; reg_list = list; base_addr = base; base_reg = br; wb_en = wb;
    st = cyc;
    @(posedge clk); #1;
    start = 1'b1; is_load = ~ld; reg_list = 8'($urandom); base_addr = $urandom;
    base_reg = 3'($urandom); wb_en = 1'($urandom);
    got = 1'b0; dc = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dc = cyc;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
    if (!got) exp_q.delete();
    lat  = dc - st;
    reqs = req_cnt - r0;
    wrs  = wr_cnt - w0;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int          lat, reqs, wrs, r0, w0;
    logic [31:0] saved, rb;
    logic [7:0]  rl;

    for (int i = 0; i < 8; i++) model_rf[i] = $urandom;
    model_rf[0] = 32'h0000_000A;
    model_rf[2] = 32'h0000_000B;

    // Reset with an aggressive start pending: nothing may begin.
    rst_n = 1'b0; load_rf = 1'b1; ready_mode = 0;
    start = 1'b1; reg_list = 8'hFF; is_load = 1'b1; wb_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_write_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rd_addr", {28'd0, rf_read_addr}, 32'd0);
    chk("rst_wr_addr", {28'd0, rf_write_addr}, 32'd0);
    chk("rst_wr_data", rf_write_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; load_rf = 1'b0; start = 1'b0;

    run_op(1'b0, 8'h05, 32'h0000_1000, 3'd3, 1'b1, lat, reqs, wrs);
    chk("stm_latency", lat, 32'd4);
    chk("stm_reqs", reqs, 32'd2);
    chk("stm_writes", wrs, 32'd1);

    ready_mode = 2; use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF;
    run_op(1'b1, 8'h80, 32'h0000_2000, 3'd0, 1'b0, lat, reqs, wrs);
    chk("ldm_wait_reqs", reqs, 32'd4);
    chk("ldm_wait_writes", wrs, 32'd1);
    chk("ldm_wait_latency", lat, 32'd5);
    ready_mode = 0; use_fixed = 1'b0;

    run_op(1'b1, 8'h03, 32'h0000_3000, 3'd1, 1'b1, lat, reqs, wrs);
    chk("ldm_base_latency", lat, 32'd3);
    chk("ldm_base_writes", wrs, 32'd2);

    run_op(1'b0, 8'h00, 32'h0000_4000, 3'd2, 1'b1, lat, reqs, wrs);
    chk("empty_latency", lat, 32'd1);
    chk("empty_reqs", reqs, 32'd0);
    chk("empty_writes", wrs, 32'd0);

    run_op(1'b0, 8'h03, 32'hFFFF_FFFC, 3'd5, 1'b1, lat, reqs, wrs);
    chk("wrap_latency", lat, 32'd4);

    // Reset during the second of four transfers.
    saved = model_rf[6];
    expect_op(1'b0, 8'h0F, 32'h0000_5000, 3'd6, 1'b1);
    model_rf[6] = saved;
    r0 = req_cnt; w0 = wr_cnt;
    start = 1'b1; is_load = 1'b0; reg_list = 8'h0F; base_addr = 32'h0000_5000;
    base_reg = 3'd6; wb_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; reg_list = 8'hF0; base_addr = 32'h0000_9000;
    @(posedge clk); #1;
    start = 1'b0; ready_mode = 3; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_req", {31'd0, mem_req}, 32'd0);
    ready_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_writes", wr_cnt - w0, 32'd0);
    chk("abort_reqs", req_cnt - r0, 32'd1);

    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      rl = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      rb = $urandom;
      rb[1:0] = 2'b00;
      if ((n % 7) == 3) rb = 32'hFFFF_FFF0;
      run_op(1'($urandom), rl, rb, 3'($urandom), 1'($urandom), lat, reqs, wrs);
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
